// File: rtl/smaqa_pkg.sv
// smaqa_pkg: shared op/state encodings and field layout for the packed-int8 MAC sequencer
package smaqa_pkg;
  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ACC  = 2'd2,
    OP_READ = 2'd3
  } smaqa_op_t;
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLED,
    ST_STREAMING
  } smaqa_state_t;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  localparam int READ_CNT_LSB = 0;
  localparam int READ_RD_LSB = 8;
endpackage

// File: rtl/smaqa_dot4.sv
// smaqa_dot4: 4-lane u8 x s8 dot product plus 32-bit addend, mod 2^32
module smaqa_dot4 import smaqa_pkg::*; (
  input  logic [31:0] weight,
  input  logic [31:0] act,
  input  logic [31:0] addend,
  output logic [31:0] sum
);
  logic [31:0] prod [LANES];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    // weight byte zero-extends, activation byte sign-extends; low 32 bits of the product are exact
    assign prod[k] = 32'(weight[k*LANE_W +: LANE_W]) * 32'(signed'(act[k*LANE_W +: LANE_W]));
  end
  always_comb begin
    sum = addend;
    for (int i = 0; i < LANES; i++) sum = sum + prod[i];
  end
endmodule

// File: rtl/smaqa_stream_ctrl.sv
// smaqa_stream_ctrl: weight buffer, read/write pointers and 1-entry result register
// sequencing CLR/LOAD/ACC/READ ops for the packed-int8 MAC path.
module smaqa_stream_ctrl import smaqa_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  smaqa_op_t                op_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_c_i,
  output logic                     valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  smaqa_state_t state_q, state_d;
  logic [PW:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [XLEN-1:0] wbuf [DEPTH];
  logic [XLEN-1:0] res_d;
  logic err_d, accept, full, wrap;
  logic [31:0] dot;
  assign ready_o = !valid_o || out_ready_i;
  assign accept = valid_i && ready_o;
  assign full = wr_q == (PW+1)'(DEPTH);
  assign wrap = ({1'b0, rd_q} + 1'b1) == wr_q;
  assign count_o = wr_q;
  smaqa_dot4 u_dot (
    .weight (wbuf[rd_q][31:0]),
    .act    (operand_a_i[31:0]),
    .addend (operand_c_i[31:0]),
    .sum    (dot)
  );
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    res_d = '0;
    err_d = 1'b0;
    if (accept) begin
      case (op_i)
        OP_CLR: begin
          state_d = ST_EMPTY;
          wr_d = '0;
          rd_d = '0;
        end
        OP_LOAD: begin
          wr_d = full ? wr_q : wr_q + 1'b1;
          state_d = (state_q == ST_EMPTY) ? ST_FILLED : state_q;
          res_d = XLEN'(wr_d);
          err_d = full;
        end
        OP_ACC: begin
          if (state_q == ST_EMPTY) begin
            res_d = operand_c_i;
            err_d = 1'b1;
          end else begin
            res_d = XLEN'(signed'(dot));
            rd_d = wrap ? '0 : rd_q + 1'b1;
            state_d = wrap ? ST_FILLED : ST_STREAMING;
          end
        end
        OP_READ: res_d = (XLEN'(rd_q) << READ_RD_LSB) | (XLEN'(wr_q) << READ_CNT_LSB);
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      wr_q <= '0;
      rd_q <= '0;
      valid_o <= 1'b0;
      result_o <= '0;
      trans_id_o <= '0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (accept) begin
        valid_o <= 1'b1;
        result_o <= res_d;
        trans_id_o <= trans_id_i;
        err_o <= err_d;
      end else if (out_ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept && op_i == OP_LOAD && !full) wbuf[wr_q[PW-1:0]] <= operand_a_i;
  end
endmodule

// File: tb/tb_smaqa_stream_ctrl.sv
// tb_smaqa_stream_ctrl: directed plus random ops against a queue-based reference model
module tb_smaqa_stream_ctrl;
  import smaqa_pkg::*;
  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int TB = 3;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic valid_i = 1'b0;
  logic out_ready_i = 1'b1;
  smaqa_op_t op_i = OP_CLR;
  logic [TB-1:0] trans_id_i = '0;
  logic [XLEN-1:0] operand_a_i = '0;
  logic [XLEN-1:0] operand_c_i = '0;
  logic ready_o, valid_o, err_o;
  logic [XLEN-1:0] result_o;
  logic [TB-1:0] trans_id_o;
  logic [CW-1:0] count_o;
  int total = 0;
  int bad = 0;
  logic [31:0] mw[$];
  int mrd = 0;

  smaqa_stream_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .TRANS_ID_BITS(TB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .trans_id_i(trans_id_i), .operand_a_i(operand_a_i), .operand_c_i(operand_c_i),
    .valid_o(valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .trans_id_o(trans_id_o), .err_o(err_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_dot(input logic [31:0] w, input logic [31:0] a, input logic [31:0] c);
    int s;
    s = int'(c);
    for (int k = 0; k < 4; k++) s += int'(w[8*k +: 8]) * int'($signed(a[8*k +: 8]));
    return s;
  endfunction

  task automatic model(input smaqa_op_t op, input logic [31:0] a, input logic [31:0] c,
                       output logic [31:0] r, output logic e);
    r = 0;
    e = 1'b0;
    case (op)
      OP_CLR: begin
        mw.delete();
        mrd = 0;
      end
      OP_LOAD: begin
        if (mw.size() < DEPTH) mw.push_back(a);
        else e = 1'b1;
        r = mw.size();
      end
      OP_ACC: begin
        if (mw.size() == 0) begin
          r = c;
          e = 1'b1;
        end else begin
          r = ref_dot(mw[mrd], a, c);
          mrd = (mrd + 1 == mw.size()) ? 0 : mrd + 1;
        end
      end
      OP_READ: r = mrd * 256 + mw.size();
    endcase
  endtask

  task automatic run(input string tag, input smaqa_op_t op, input logic [31:0] a,
                     input logic [31:0] c, output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    logic [TB-1:0] tid;
    int n;
    model(op, a, c, er, ee);
    tid = TB'($urandom);
    op_i = op;
    operand_a_i = a;
    operand_c_i = c;
    trans_id_i = tid;
    valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_ready"}, 32'(n < 50), 32'd1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_result"}, result_o, er);
    chk({tag, "_err"}, 32'(err_o), 32'(ee));
    chk({tag, "_tid"}, 32'(trans_id_o), 32'(tid));
    chk({tag, "_count"}, 32'(count_o), mw.size());
    got = result_o;
  endtask

  initial begin
    logic [31:0] g, e1, e2, a;
    logic f1, f2;
    logic [TB-1:0] t1, t2;
    int r;
    #1 rst_ni = 1'b0;
    #20;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_result", result_o, 0);
    chk("rst_tid", 32'(trans_id_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_count", 32'(count_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    // reset while an ACC result is pending
    run("t1_load", OP_LOAD, 32'h11223344, 0, g);
    op_i = OP_ACC;
    operand_a_i = 32'h01010101;
    operand_c_i = 0;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("t1_rst_valid", 32'(valid_o), 0);
    chk("t1_rst_ready", 32'(ready_o), 1);
    chk("t1_rst_count", 32'(count_o), 0);
    valid_i = 1'b0;
    mw.delete();
    mrd = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t1_no_valid", 32'(valid_o), 0);
    run("t1_acc_empty", OP_ACC, 32'h01010101, 32'h00001234, g);
    chk("t1_acc_empty_c", g, 32'h00001234);
    // two-entry stream wrap
    run("t2_clr", OP_CLR, 0, 0, g);
    run("t2_ld0", OP_LOAD, 32'h01020304, 0, g);
    run("t2_ld1", OP_LOAD, 32'hFFFFFFFF, 0, g);
    run("t2_acc0", OP_ACC, 32'h01010101, 0, g);
    chk("t2_acc0_k", g, 32'd10);
    run("t2_acc1", OP_ACC, 32'h01010101, 5, g);
    chk("t2_acc1_k", g, 32'd1025);
    run("t2_acc2", OP_ACC, 32'h01010101, 0, g);
    chk("t2_acc2_k", g, 32'd10);
    // signedness and mod-2^32 wrap
    run("t3_clr", OP_CLR, 0, 0, g);
    run("t3_ld", OP_LOAD, 32'h00000080, 0, g);
    run("t3_neg", OP_ACC, 32'h000000FF, 0, g);
    chk("t3_neg_k", g, 32'hFFFFFF80);
    run("t3_clr2", OP_CLR, 0, 0, g);
    run("t3_ld2", OP_LOAD, 32'h000000FF, 0, g);
    run("t3_wrap", OP_ACC, 32'h7F7F7F7F, 32'h7FFFFFF0, g);
    chk("t3_wrap_k", g, 32'h80007E71);
    // READ field packing
    run("t6_clr", OP_CLR, 0, 0, g);
    for (int i = 0; i < 3; i++) run("t6_ld", OP_LOAD, $urandom, 0, g);
    run("t6_acc", OP_ACC, $urandom, $urandom, g);
    run("t6_read", OP_READ, 0, 0, g);
    chk("t6_read_k", g, 32'h00000103);
    run("t6_clr2", OP_CLR, 0, 0, g);
    run("t6_read2", OP_READ, 0, 0, g);
    chk("t6_read2_k", g, 32'h0);
    // fill to DEPTH, then overflow
    run("t4_clr", OP_CLR, 0, 0, g);
    run("t4_ld0", OP_LOAD, 32'h01010101, 0, g);
    for (int i = 1; i < DEPTH; i++) run("t4_ld", OP_LOAD, $urandom, 0, g);
    chk("t4_full_k", g, DEPTH);
    run("t4_over", OP_LOAD, 32'hDEADBEEF, 0, g);
    chk("t4_over_res", g, DEPTH);
    chk("t4_over_err", 32'(err_o), 1);
    chk("t4_over_cnt", 32'(count_o), DEPTH);
    run("t4_acc", OP_ACC, 32'h01010101, 0, g);
    chk("t4_acc_k", g, 32'd4);
    // backpressure: hold the result, queue a READ behind it
    a = $urandom;
    model(OP_ACC, a, 32'h55, e1, f1);
    t1 = TB'($urandom);
    op_i = OP_ACC;
    operand_a_i = a;
    operand_c_i = 32'h55;
    trans_id_i = t1;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
    model(OP_READ, 0, 0, e2, f2);
    t2 = t1 + 1'b1;
    op_i = OP_READ;
    trans_id_i = t2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t5_ready", 32'(ready_o), 0);
      chk("t5_valid", 32'(valid_o), 1);
      chk("t5_hold_res", result_o, e1);
      chk("t5_hold_err", 32'(err_o), 32'(f1));
      chk("t5_hold_tid", 32'(trans_id_o), 32'(t1));
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    chk("t5_next_valid", 32'(valid_o), 1);
    chk("t5_next_res", result_o, e2);
    chk("t5_next_tid", 32'(trans_id_o), 32'(t2));
    // random op mix
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) run("rnd_clr", OP_CLR, $urandom, $urandom, g);
      else if (r < 9) run("rnd_load", OP_LOAD, $urandom, $urandom, g);
      else if (r < 18) run("rnd_acc", OP_ACC, $urandom, $urandom, g);
      else run("rnd_read", OP_READ, $urandom, $urandom, g);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/smaqa_stream_ctrl.md
Name: smaqa_stream_ctrl

Overview:
- Sequencer for the packed-int8 multiply-accumulate (SMAQA-style) path in the multiplier functional unit.
- Software loads a weight vector word by word into a local DEPTH-entry buffer.
- Each subsequent ACC op pairs the next buffered weight word with an incoming activation word. It computes a 4-lane u8×s8 dot product plus an addend and returns the result.
- Sits beside the multiplier in the issue/writeback path and uses the same trans_id and valid/ready conventions.

Parameters:
- XLEN, 32, operand/result width (≥32).
- DEPTH, 16, buffer entries; power of two, ≥2.
- TRANS_ID_BITS, 3, transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- valid_i  in  1  op request.
- ready_o  out  1  op accepted when valid_i && ready_o.
- op_i  in  2  smaqa_op_t: CLR=0, LOAD=1, ACC=2, READ=3.
- trans_id_i  in  TRANS_ID_BITS  tag of the op.
- operand_a_i  in  XLEN  LOAD: weight word; ACC: activation word.
- operand_c_i  in  XLEN  ACC addend.
- valid_o  out  1  result valid.
- out_ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  result.
- trans_id_o  out  TRANS_ID_BITS  tag of the result.
- err_o  out  1  op was illegal; qualified by valid_o.
- count_o  out  $clog2(DEPTH)+1  words currently loaded.

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
- Reset values:
  - Outputs: valid_o=0, result_o=0, trans_id_o=0, err_o=0, count_o=0.
  - Internal: wr_ptr=0, rd_ptr=0, state=EMPTY.
  - Buffer contents are not reset.
  - Reset mid-operation discards any pending result; no valid_o follows.
- Handshake:
  - 1-entry output register; ready_o = !valid_o || out_ready_i.
  - An accepted op produces valid_o in the next cycle, latency 1.
  - While valid_o=1 && out_ready_i=0, result_o, trans_id_o and err_o hold stable.
  - Back-to-back ops at full throughput when out_ready_i=1.
- States: EMPTY (wr_ptr=0), FILLED (wr_ptr>0, rd_ptr=0), STREAMING (rd_ptr>0).
- CLR:
  - wr_ptr=rd_ptr=0, next state EMPTY; result 0, err 0.
  - Legal in any state.
- LOAD:
  - If wr_ptr<DEPTH: buf[wr_ptr]<=operand_a_i, wr_ptr++, state FILLED if it was EMPTY (STREAMING stays STREAMING); result = new count, err 0.
  - If full: write dropped, count unchanged, result = DEPTH, err 1.
- ACC:
  - If EMPTY: result = operand_c_i, err 1, pointers unchanged.
  - Else w = buf[rd_ptr] and result = operand_c_i[31:0] + Σ_{k=0..3} $unsigned(w[8k+7:8k]) × $signed(a[8k+7:8k]).
  - Computed mod 2^32, then sign-extended from bit 31 to XLEN.
  - rd_ptr advances; when rd_ptr+1==wr_ptr it wraps to 0 and the state becomes FILLED, otherwise STREAMING.
- READ: result = {rd_ptr, count} zero-extended, with rd_ptr in bits [15:8] and count in [7:0]; err 0; no state change.
- Only one op per cycle, so a buffer write and read never coincide.
- A LOAD during STREAMING appends; the wrap point follows the updated wr_ptr.
- count_o = wr_ptr registered, updated in the cycle after LOAD/CLR acceptance.

Decomposition:
- Package smaqa_pkg holds:
  - smaqa_op_t enum;
  - LANES=4 and LANE_W=8;
  - READ-result field offsets.
- Sub-module smaqa_dot4, purely combinational:
  - inputs weight word, activation word, addend;
  - output 32-bit sum.
- Controller FSM, pointers, buffer and output register stay in smaqa_stream_ctrl.

Test Plan:
1. Reset mid-ACC (valid_i=1, rst_ni pulsed low) -> valid_o=0, ready_o=1, count_o=0; next ACC returns err_o=1 with result = operand_c_i.
2. LOAD 0x01020304, LOAD 0xFFFFFFFF (count_o 1→2) -> ACC a=0x01010101 c=0 gives 10; ACC a=0x01010101 c=5 gives 1025 with rd_ptr wrapped to 0; a third ACC a=0x01010101 c=0 gives 10 again.
3. CLR; LOAD 0x00000080; ACC a=0x000000FF c=0 -> result 0xFFFFFF80 (128 × −1); ACC a=0x7F7F7F7F c=0x7FFFFFF0 with buf 0x000000FF -> 0x7FFFFFF0+32385, wrapping mod 2^32.
4. CLR, then DEPTH LOADs (count 16, err 0), then a 17th LOAD -> err_o=1, result 16, count_o stays 16; ACC still reads entry 0.
5. Hold out_ready_i=0 with valid_o=1 for 3 cycles -> ready_o=0, outputs stable, no op accepted; raise out_ready_i -> pending result retired and the queued op accepted in the same cycle.
6. READ after 3 LOADs and 1 ACC -> result 0x0103; CLR then READ -> 0x0000.
